// File: rtl/gate_pulse_recover_pkg.sv
// Shared definitions for the gate-to-pulse recovery block.
//   state_t   : FSM encoding (IDLE=0, QUALIFY=1, ACTIVE=2, STUCK=3), also
//               usable by benches of the companion pulse-to-gate stretcher.
//   cnt_op_t  : command set of the saturating width counter.
//   params_ok : parameter-range check evaluated at elaboration.
package gate_pulse_recover_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_QUALIFY = 2'd1,
    ST_ACTIVE  = 2'd2,
    ST_STUCK   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CNT_HOLD  = 2'd0,
    CNT_CLEAR = 2'd1,
    CNT_LOAD1 = 2'd2,
    CNT_INC   = 2'd3
  } cnt_op_t;

  // MIN_LEN >= 1, MAX_LEN > MIN_LEN and MAX_LEN must fit in CNT_W bits.
  function automatic bit params_ok(input int min_len, input int max_len,
                                   input int cnt_w);
    longint cnt_max;
    cnt_max = (longint'(1) << cnt_w) - 1;
    return (min_len >= 1) && (max_len > min_len) &&
           (longint'(max_len) <= cnt_max);
  endfunction

endpackage

// File: rtl/gate_pulse_recover_sat_counter.sv
// Saturating width counter for gate_pulse_recover.
//   clk_i    : system clock, rising edge
//   resetn_i : asynchronous active-low reset (count returns to 0)
//   op       : HOLD / CLEAR / LOAD1 / INC
//   cnt      : current count, never exceeds MAX_LEN
module gate_pulse_recover_sat_counter
  import gate_pulse_recover_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int MAX_LEN = 32
) (
  input  logic             clk_i,
  input  logic             resetn_i,
  input  cnt_op_t          op,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_LEN);

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge value of its inputs, independent of process evaluation order.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      cnt <= '0;
    end else begin
      case (op)
        CNT_CLEAR: cnt <= '0;
        CNT_LOAD1: cnt <= CNT_W'(1);
        CNT_INC:   if (cnt != MAX_C) cnt <= cnt + CNT_W'(1);
        default:   cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/gate_pulse_recover.sv
// Converts a stretched gate back into a single-cycle pulse and measures the
// gate width. Gates shorter than MIN_LEN are rejected as glitches; gates
// that reach MAX_LEN high samples are flagged as stuck.
//   clk_i         : system clock, rising edge
//   resetn_i      : asynchronous active-low reset
//   gate_i        : gate input, already synchronous to clk_i
//   pulse_o       : one-cycle pulse per qualified gate
//   width_o       : high-sample count of the last completed gate
//   width_valid_o : one-cycle strobe, width_o updated for a qualified gate
//   short_err_o   : one-cycle strobe, gate dropped before MIN_LEN
//   long_err_o    : one-cycle strobe, gate reached MAX_LEN
//   busy_o        : high while a gate is being tracked
module gate_pulse_recover
  import gate_pulse_recover_pkg::*;
#(
  parameter int MIN_LEN = 2,
  parameter int MAX_LEN = 32,
  parameter int CNT_W   = 8
) (
  input  logic             clk_i,
  input  logic             resetn_i,
  input  logic             gate_i,
  output logic             pulse_o,
  output logic [CNT_W-1:0] width_o,
  output logic             width_valid_o,
  output logic             short_err_o,
  output logic             long_err_o,
  output logic             busy_o
);

  if (!params_ok(MIN_LEN, MAX_LEN, CNT_W)) begin : g_param_err
    $error("gate_pulse_recover: need MIN_LEN>=1, MAX_LEN>MIN_LEN, MAX_LEN<=2^CNT_W-1");
  end

  localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_LEN);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_LEN);

  state_t           state, state_next;
  cnt_op_t          cnt_op;
  logic [CNT_W-1:0] cnt, cnt_inc, width_next;
  logic             pulse_next, wv_next, short_next, long_next;

  gate_pulse_recover_sat_counter #(
    .CNT_W   (CNT_W),
    .MAX_LEN (MAX_LEN)
  ) u_cnt (
    .clk_i    (clk_i),
    .resetn_i (resetn_i),
    .op       (cnt_op),
    .cnt      (cnt)
  );

  // Only used in QUALIFY/ACTIVE where cnt < MAX_LEN, so it cannot wrap.
  assign cnt_inc = cnt + CNT_W'(1);

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    cnt_op     = CNT_HOLD;
    width_next = width_o;
    pulse_next = 1'b0;
    wv_next    = 1'b0;
    short_next = 1'b0;
    long_next  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (gate_i) begin
          cnt_op = CNT_LOAD1;
          if (MIN_LEN == 1) begin
            state_next = ST_ACTIVE;
            pulse_next = 1'b1;
          end else begin
            state_next = ST_QUALIFY;
          end
        end
      end
      ST_QUALIFY: begin
        if (gate_i) begin
          cnt_op = CNT_INC;
          if (cnt_inc == MIN_C) begin
            state_next = ST_ACTIVE;
            pulse_next = 1'b1;
          end
        end else begin
          cnt_op     = CNT_CLEAR;
          width_next = cnt;
          short_next = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (gate_i) begin
          cnt_op = CNT_INC;
          if (cnt_inc == MAX_C) begin
            state_next = ST_STUCK;
            long_next  = 1'b1;
          end
        end else begin
          cnt_op     = CNT_CLEAR;
          width_next = cnt;
          wv_next    = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_STUCK: begin
        // Silent until the gate finally drops; width reports the ceiling.
        if (!gate_i) begin
          cnt_op     = CNT_CLEAR;
          width_next = MAX_C;
          state_next = ST_IDLE;
        end
      end
      default: begin
        cnt_op     = CNT_CLEAR;
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state         <= ST_IDLE;
      width_o       <= '0;
      pulse_o       <= 1'b0;
      width_valid_o <= 1'b0;
      short_err_o   <= 1'b0;
      long_err_o    <= 1'b0;
      busy_o        <= 1'b0;
    end else begin
      state         <= state_next;
      width_o       <= width_next;
      pulse_o       <= pulse_next;
      width_valid_o <= wv_next;
      short_err_o   <= short_next;
      long_err_o    <= long_next;
      busy_o        <= (state_next != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_gate_pulse_recover.sv
// Scoreboard bench for gate_pulse_recover: a default build (MIN_LEN=2,
// MAX_LEN=32) and a MIN_LEN=1 build share clock and reset. Stimulus tasks
// push the expected strobes (cycle, strobe vector, width) into a queue per
// DUT; independent monitors pop and compare whenever a strobe appears.
module tb_gate_pulse_recover;

  localparam int CNT_W = 8;
  localparam int MAX_L = 32;

  typedef struct {
    int         cyc;
    logic [3:0] s;      // {long_err, short_err, width_valid, pulse}
    logic [7:0] w;
    bit         chk_w;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic g0 = 1'b0, g1 = 1'b0;
  logic p0, wv0, se0, le0, b0, p1, wv1, se1, le1, b1;
  logic [CNT_W-1:0] w0, w1;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gate_pulse_recover #(.MIN_LEN(2), .MAX_LEN(MAX_L), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .resetn_i(rst_n), .gate_i(g0), .pulse_o(p0), .width_o(w0),
    .width_valid_o(wv0), .short_err_o(se0), .long_err_o(le0), .busy_o(b0));

  gate_pulse_recover #(.MIN_LEN(1), .MAX_LEN(MAX_L), .CNT_W(CNT_W)) dut1 (
    .clk_i(clk), .resetn_i(rst_n), .gate_i(g1), .pulse_o(p1), .width_o(w1),
    .width_valid_o(wv1), .short_err_o(se1), .long_err_o(le1), .busy_o(b1));

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic exp_t mk(input int c, input logic [3:0] s,
                              input int w, input bit chk_w);
    exp_t e;
    e.cyc = c; e.s = s; e.w = 8'(w); e.chk_w = chk_w;
    return e;
  endfunction

  // Monitors: any strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    logic [3:0] s;
    exp_t e;
    s = {le0, se0, wv0, p0};
    if (rst_n && s != 4'b0) begin
      if (q0.size() == 0) check("dut0_unexpected_strobe", longint'(s), 0);
      else begin
        e = q0.pop_front();
        check("dut0_strobe_cycle", cyc, e.cyc);
        check("dut0_strobe_kind", longint'(s), longint'(e.s));
        if (e.chk_w) check("dut0_width", longint'(w0), longint'(e.w));
      end
    end
  end

  always @(negedge clk) begin
    logic [3:0] s;
    exp_t e;
    s = {le1, se1, wv1, p1};
    if (rst_n && s != 4'b0) begin
      if (q1.size() == 0) check("dut1_unexpected_strobe", longint'(s), 0);
      else begin
        e = q1.pop_front();
        check("dut1_strobe_cycle", cyc, e.cyc);
        check("dut1_strobe_kind", longint'(s), longint'(e.s));
        if (e.chk_w) check("dut1_width", longint'(w1), longint'(e.w));
      end
    end
  end

  // Drive one gate of w high samples then lo low samples on the selected DUT.
  // Called at a negedge; edge k is the next rising edge.
  task automatic run_gate(input int sel, input int min_len, input int w,
                          input int lo);
    int k;
    k = cyc + 1;
    if (w < min_len) begin
      if (sel == 0) q0.push_back(mk(k + w, 4'b0100, w, 1'b1));
      else          q1.push_back(mk(k + w, 4'b0100, w, 1'b1));
    end else begin
      if (sel == 0) q0.push_back(mk(k + min_len - 1, 4'b0001, 0, 1'b0));
      else          q1.push_back(mk(k + min_len - 1, 4'b0001, 0, 1'b0));
      if (w < MAX_L) begin
        if (sel == 0) q0.push_back(mk(k + w, 4'b0010, w, 1'b1));
        else          q1.push_back(mk(k + w, 4'b0010, w, 1'b1));
      end else begin
        if (sel == 0) q0.push_back(mk(k + MAX_L - 1, 4'b1000, 0, 1'b0));
        else          q1.push_back(mk(k + MAX_L - 1, 4'b1000, 0, 1'b0));
      end
    end
    for (int i = 0; i < w; i++) begin
      if (sel == 0) g0 = 1'b1; else g1 = 1'b1;
      @(negedge clk);
    end
    check("busy_during_gate", (sel == 0) ? b0 : b1, 1);
    if (sel == 0) g0 = 1'b0; else g1 = 1'b0;
    @(negedge clk);
    check("busy_after_drop", (sel == 0) ? b0 : b1, 0);
    if (w >= MAX_L) check("stuck_width", (sel == 0) ? w0 : w1, MAX_L);
    for (int i = 1; i < lo; i++) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    repeat (3) @(negedge clk);
    check("rst_pulse", p0, 0);
    check("rst_width", w0, 0);
    check("rst_busy", b0, 0);
    check("rst_strobes", {le0, se0, wv0}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_gate(0, 2, 4, 3);    // nominal gate
    run_gate(0, 2, 1, 3);    // glitch
    run_gate(0, 2, 40, 3);   // stuck gate
    run_gate(0, 2, 3, 1);    // back-to-back, single low cycle
    run_gate(0, 2, 3, 3);
    run_gate(0, 2, 2, 2);    // shortest qualified
    run_gate(0, 2, 31, 3);   // longest qualified

    // Reset mid-gate at cnt=5, gate held high through release.
    k = cyc + 1;
    q0.push_back(mk(k + 1, 4'b0001, 0, 1'b0));
    g0 = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", b0, 0);
    check("midrst_width", w0, 0);
    check("midrst_strobes", {le0, se0, wv0, p0}, 0);
    @(negedge clk);
    check("midrst_busy_held", b0, 0);
    rst_n = 1'b1;
    k = cyc + 1;
    q0.push_back(mk(k + 1, 4'b0001, 0, 1'b0));
    q0.push_back(mk(k + 3, 4'b0010, 3, 1'b1));
    repeat (3) @(negedge clk);
    g0 = 1'b0;
    repeat (3) @(negedge clk);

    // MIN_LEN=1 build.
    run_gate(1, 1, 1, 2);
    run_gate(1, 1, 3, 2);

    repeat (4) @(negedge clk);
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gate_pulse_recover.md
Name: gate_pulse_recover

Overview:
- Receive-side counterpart to the pulse-to-gate stretcher: converts a stretched gate back into a single-cycle pulse and measures the gate width.
- Rejects gates shorter than MIN_LEN as glitches.
- Flags gates that stay high for MAX_LEN cycles or more as stuck.
- Sits in the clk_i domain wherever a stretched gate returns from a slower or remote consumer and must be turned back into an event plus a width check.

Parameters:
- MIN_LEN, 2, minimum consecutive high samples for a gate to qualify (>=1)
- MAX_LEN, 32, high-sample count at which the gate is declared stuck (>MIN_LEN, <=2^CNT_W-1)
- CNT_W, 8, width counter / width_o width

Ports:
- clk_i  in  1  system clock, all logic on rising edge
- resetn_i  in  1  asynchronous active-low reset
- gate_i  in  1  synchronous gate input (already in clk_i domain)
- pulse_o  out  1  one-cycle pulse per qualified gate
- width_o  out  CNT_W  measured high-sample count of last completed gate
- width_valid_o  out  1  one-cycle strobe, width_o updated
- short_err_o  out  1  one-cycle strobe, gate dropped before MIN_LEN
- long_err_o  out  1  one-cycle strobe, gate reached MAX_LEN
- busy_o  out  1  high while a gate is being tracked

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: state IDLE, cnt=0, all outputs 0 (width_o=0). Reset mid-gate aborts without any strobe.
- Counter: cnt (CNT_W bits) = number of consecutive rising edges at which gate_i was sampled high. All outputs are registered.
- Timing reference: edge k is the first edge at which gate_i is high while in IDLE.
- IDLE:
  - gate_i=1 -> cnt<=1.
  - If MIN_LEN==1 -> ACTIVE, pulse_o<=1. Else -> QUALIFY.
- QUALIFY, gate_i=1: cnt<=cnt+1. If cnt+1==MIN_LEN -> ACTIVE, pulse_o<=1.
- QUALIFY, gate_i=0: short_err_o<=1, width_o<=cnt, no width_valid_o, -> IDLE.
- ACTIVE, gate_i=1: cnt<=cnt+1. If cnt+1==MAX_LEN -> STUCK, long_err_o<=1.
- ACTIVE, gate_i=0: width_o<=cnt, width_valid_o<=1, -> IDLE.
- STUCK:
  - Hold cnt, no outputs.
  - On gate_i=0 -> IDLE, width_o<=MAX_LEN, no width_valid_o.
  - No further strobes while gate_i stays high.
- Resulting latency:
  - pulse_o is high in the cycle after edge k+MIN_LEN-1.
  - A gate high for W edges (MIN_LEN<=W<MAX_LEN) gives width_o=W and width_valid_o in the cycle after edge k+W (the first low sample).
  - Qualified widths range from MIN_LEN to MAX_LEN-1.
- Strobes: pulse_o, width_valid_o, short_err_o and long_err_o are each exactly one cycle and default to 0 every cycle. At most one of them is high in any cycle.
- busy_o = (state != IDLE), registered with the state.
- Back-to-back gates: the IDLE transition occurs on the first low sample. A single low cycle between gates is enough for the next gate to be detected, with its count starting at 1.
- Gate held high through reset release: treated as a new gate; edge k is the first edge after deassertion.
- Counter arithmetic: cnt never exceeds MAX_LEN, so it cannot wrap.
- Elaboration check: violating MIN_LEN>=1, MAX_LEN>MIN_LEN or MAX_LEN<=2^CNT_W-1 is an elaboration error.

Decomposition:
- Shared package/include: state encodings (IDLE=0, QUALIFY=1, ACTIVE=2, STUCK=3) and the parameter-range check macro, reused by the stretcher testbench.
- One natural sub-module: sat_counter (CNT_W, load-1 / increment / hold / clear, saturates at MAX_LEN).
- The FSM and output registers stay in the top.

Test Plan:
1. Defaults; gate high 4 cycles -> pulse_o one cycle after the 2nd high edge; width_o=4 and width_valid_o one cycle after the first low edge; no errors.
2. Gate high 1 cycle -> short_err_o one cycle, width_o=1, no pulse_o, no width_valid_o.
3. Gate high 40 cycles -> pulse_o once; long_err_o one cycle after the 32nd high edge; busy_o held until the first low sample; width_o=32; no width_valid_o.
4. Two 3-cycle gates separated by 1 low cycle -> two pulse_o, two width_valid_o each with width_o=3.
5. Assert resetn_i=0 mid-gate at cnt=5, release with gate_i still high for 3 more cycles -> all outputs 0 during reset; after release one pulse_o; width_o=3.
6. MIN_LEN=1 build; gate high 1 cycle -> pulse_o in the cycle after edge k; width_valid_o with width_o=1.
